lsu_mem_port: RTL and testbench

Load/store unit front end that drives the data memory on behalf of the execute stage. It accepts one byte-addressed load or store at a time with RISC-V funct3 size/sign encoding. It converts each request into one or two word-wide memory accesses with byte enables, splitting misaligned accesses across word boundaries. For loads, it reassembles and sign- or zero-extends the returned data before handing a response back to the pipeline.

---
 rtl/lsu_mem_port.sv | 158 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store front end: turns one byte-addressed request into one or two word accesses.
// Latency: aligned load 3, split load 4, aligned store 2, split store 3 cycles to resp_valid.
// Backpressure: req_ready high only in IDLE; requests seen while busy are ignored.
//
// Ports: clk/rst_n (async active-low); req_* request from execute (valid/ready);
// resp_valid/resp_rdata completion pulse with extended load data;
// mem_* synchronous single-port data memory (read data valid the cycle after a read).
module lsu_mem_port #(
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, FIRST, SECOND, WAIT, RESP} state_t;

  state_t state, state_nxt;

  // Latched request
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [MEM_AW-1:0] w0_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word0_q;

  // Address bits above the memory's reach are don't-care (addresses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

  // Derived from the latched request only, so no req_* -> mem_* path exists.
  logic [3:0]        mask;
  logic [7:0]        wide_be;
  logic [63:0]       wide_wd;
  logic              split;
  logic [MEM_AW-1:0] w1;

  assign mask    = funct3_q[1] ? 4'b1111 : (funct3_q[0] ? 4'b0011 : 4'b0001);
  assign wide_be = {4'b0000, mask} << off_q;
  assign wide_wd = {32'b0, wdata_q} << {off_q, 3'b000};
  assign split   = |wide_be[7:4];
  assign w1      = w0_q + MEM_AW'(1);

  // Load reassembly: in WAIT the live read data is word0 for a single access,
  // or word1 when word0 was already captured during SECOND.
  logic [31:0] lo_word, hi_word, raw, ext;
  logic        sx;

  assign lo_word = split ? word0_q : mem_rdata;
  assign hi_word = split ? mem_rdata : 32'b0;
  assign raw     = 32'({hi_word, lo_word} >> {off_q, 3'b000});
  assign sx      = ~funct3_q[2];

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   ext = {{24{sx & raw[7]}}, raw[7:0]};
      2'b01:   ext = {{16{sx & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and decoded outputs
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = 32'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = FIRST;
      end
      FIRST: begin
        mem_en    = 1'b1;
        mem_we    = store_q;
        mem_addr  = w0_q;
        mem_be    = wide_be[3:0];
        mem_wdata = wide_wd[31:0];
        if (split)        state_nxt = SECOND;
        else if (store_q) state_nxt = RESP;
        else              state_nxt = WAIT;
      end
      SECOND: begin
        mem_en    = 1'b1;
        mem_we    = store_q;
        mem_addr  = w1;
        mem_be    = wide_be[7:4];
        mem_wdata = wide_wd[63:32];
        state_nxt = store_q ? RESP : WAIT;
      end
      WAIT: begin
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      w0_q     <= '0;
      wdata_q  <= 32'b0;
    end else if (state == IDLE && req_valid) begin
      store_q  <= req_store;
      funct3_q <= req_funct3;
      off_q    <= req_addr[1:0];
      w0_q     <= req_addr[MEM_AW+1:2];
      wdata_q  <= req_wdata;
    end
  end

  // Load data path: word0 of a split load arrives during SECOND; the final
  // result is registered in WAIT. A store clears resp_rdata on its last access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word0_q    <= 32'b0;
      resp_rdata <= 32'b0;
    end else begin
      if (state == SECOND && !store_q) word0_q <= mem_rdata;
      if (state == WAIT)
        resp_rdata <= ext;
      else if (store_q && (state == FIRST || state == SECOND) && state_nxt == RESP)
        resp_rdata <= 32'b0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port with a behavioural synchronous memory.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each scenario task checks port values cycle by cycle against hand-computed constants.
module tb_lsu_mem_port;
  localparam int AW = 14;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_port #(.MEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with a preload side channel owned by the bench.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_dat;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_dat;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  wire [51:0] mem_port = {mem_en, mem_we, mem_addr, mem_be, mem_wdata};
  wire [85:0] all_out  = {req_ready, resp_valid, resp_rdata, mem_port};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_dat  = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  // Presents one request for one cycle; returns in cycle T+1.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    step();
    req_valid  = 1'b0;
    req_wdata  = 32'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_tests++;
    if (all_out !== {1'b1, 1'b0, 32'd0, 52'd0}) begin
      n_fail++; $display("FAIL reset_outputs got %h want %h", all_out, {1'b1, 1'b0, 32'd0, 52'd0});
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if ({req_ready, resp_valid, mem_en} !== 3'b100) begin
      n_fail++; $display("FAIL reset_release_idle got %b want 100", {req_ready, resp_valid, mem_en});
    end
  endtask

  task automatic test_byte_loads();
    logic [31:0] addrs [3] = '{32'h1, 32'h3, 32'h3};
    logic [2:0]  f3s   [3] = '{3'b000, 3'b000, 3'b100};
    logic [3:0]  bes   [3] = '{4'b0010, 4'b1000, 4'b1000};
    logic [31:0] exps  [3] = '{32'h00000022, 32'hFFFFFF88, 32'h00000088};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, f3s[i], addrs[i], 32'b0);
      n_tests++;
      if (mem_port !== {2'b10, 14'd0, bes[i], 32'd0}) begin
        n_fail++; $display("FAIL byte_load%0d_access got %h want %h", i, mem_port, {2'b10, 14'd0, bes[i], 32'd0});
      end
      step();
      n_tests++;
      if ({mem_en, resp_valid, req_ready} !== 3'b000) begin
        n_fail++; $display("FAIL byte_load%0d_wait got %b want 000", i, {mem_en, resp_valid, req_ready});
      end
      step();
      n_tests++;
      if ({resp_valid, resp_rdata} !== {1'b1, exps[i]}) begin
        n_fail++; $display("FAIL byte_load%0d_resp got %h want %h", i, {resp_valid, resp_rdata}, {1'b1, exps[i]});
      end
      step();
      n_tests++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        n_fail++; $display("FAIL byte_load%0d_idle got %b want 01", i, {resp_valid, req_ready});
      end
    end
  endtask

  task automatic test_split_load();
    issue(1'b0, 3'b010, 32'h6, 32'b0);
    n_tests++;
    if (mem_port !== {2'b10, 14'd1, 4'b1100, 32'd0}) begin
      n_fail++; $display("FAIL split_lw_first got %h want %h", mem_port, {2'b10, 14'd1, 4'b1100, 32'd0});
    end
    step();
    n_tests++;
    if (mem_port !== {2'b10, 14'd2, 4'b0011, 32'd0}) begin
      n_fail++; $display("FAIL split_lw_second got %h want %h", mem_port, {2'b10, 14'd2, 4'b0011, 32'd0});
    end
    step();
    n_tests++;
    if ({mem_en, resp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL split_lw_wait got %b want 00", {mem_en, resp_valid});
    end
    step();
    n_tests++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'h2211DDCC}) begin
      n_fail++; $display("FAIL split_lw_resp got %h want %h", {resp_valid, resp_rdata}, {1'b1, 32'h2211DDCC});
    end
    step();
  endtask

  task automatic test_split_store();
    issue(1'b1, 3'b001, 32'h3, 32'h0000ABCD);
    n_tests++;
    if (mem_port !== {2'b11, 14'd0, 4'b1000, 32'hCD000000}) begin
      n_fail++; $display("FAIL split_sh_first got %h want %h", mem_port, {2'b11, 14'd0, 4'b1000, 32'hCD000000});
    end
    step();
    n_tests++;
    if (mem_port !== {2'b11, 14'd1, 4'b0001, 32'h000000AB}) begin
      n_fail++; $display("FAIL split_sh_second got %h want %h", mem_port, {2'b11, 14'd1, 4'b0001, 32'h000000AB});
    end
    step();
    n_tests++;
    if ({resp_valid, resp_rdata, mem_en} !== {1'b1, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL split_sh_resp got %h want %h", {resp_valid, resp_rdata, mem_en}, {1'b1, 32'd0, 1'b0});
    end
    n_tests++;
    if ({mem[0], mem[1]} !== {32'hCD442211, 32'hDDCCBBAB}) begin
      n_fail++; $display("FAIL split_sh_memory got %h want %h", {mem[0], mem[1]}, {32'hCD442211, 32'hDDCCBBAB});
    end
    step();
  endtask

  task automatic test_wrap();
    preload(14'd0, 32'h12345601);
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'b0);
    n_tests++;
    if (mem_port !== {2'b10, 14'h3FFF, 4'b1000, 32'd0}) begin
      n_fail++; $display("FAIL wrap_first got %h want %h", mem_port, {2'b10, 14'h3FFF, 4'b1000, 32'd0});
    end
    step();
    n_tests++;
    if (mem_port !== {2'b10, 14'h0000, 4'b0001, 32'd0}) begin
      n_fail++; $display("FAIL wrap_second got %h want %h", mem_port, {2'b10, 14'h0000, 4'b0001, 32'd0});
    end
    step();
    step();
    n_tests++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'h00000180}) begin
      n_fail++; $display("FAIL wrap_resp got %h want %h", {resp_valid, resp_rdata}, {1'b1, 32'h00000180});
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    int seen;
    issue(1'b0, 3'b010, 32'h6, 32'b0);
    step();
    n_tests++;
    if (mem_port !== {2'b10, 14'd2, 4'b0011, 32'd0}) begin
      n_fail++; $display("FAIL rst_mid_in_second got %h want %h", mem_port, {2'b10, 14'd2, 4'b0011, 32'd0});
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (all_out !== {1'b1, 1'b0, 32'd0, 52'd0}) begin
      n_fail++; $display("FAIL rst_mid_outputs got %h want %h", all_out, {1'b1, 1'b0, 32'd0, 52'd0});
    end
    seen = 0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid || mem_en) seen++;
      step();
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", seen);
    end
    issue(1'b0, 3'b010, 32'h0, 32'b0);
    n_tests++;
    if (mem_port !== {2'b10, 14'd0, 4'b1111, 32'd0}) begin
      n_fail++; $display("FAIL rst_mid_lw_access got %h want %h", mem_port, {2'b10, 14'd0, 4'b1111, 32'd0});
    end
    step();
    step();
    n_tests++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'h12345601}) begin
      n_fail++; $display("FAIL rst_mid_lw_resp got %h want %h", {resp_valid, resp_rdata}, {1'b1, 32'h12345601});
    end
    step();
  endtask

  task automatic test_back_to_back();
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h8;
    req_wdata  = 32'hCAFEF00D;
    step();
    // Second request presented immediately; must wait for IDLE.
    req_store  = 1'b0;
    req_wdata  = 32'b0;
    n_tests++;
    if ({req_ready, mem_port} !== {1'b0, 2'b11, 14'd2, 4'b1111, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL b2b_store_access got %h want %h", {req_ready, mem_port}, {1'b0, 2'b11, 14'd2, 4'b1111, 32'hCAFEF00D});
    end
    step();
    n_tests++;
    if ({req_ready, resp_valid, mem_en, resp_rdata} !== {3'b010, 32'd0}) begin
      n_fail++; $display("FAIL b2b_store_resp got %h want %h", {req_ready, resp_valid, mem_en, resp_rdata}, {3'b010, 32'd0});
    end
    step();
    n_tests++;
    if ({req_ready, resp_valid, mem_en} !== 3'b100) begin
      n_fail++; $display("FAIL b2b_second_accept got %b want 100", {req_ready, resp_valid, mem_en});
    end
    step();
    req_valid = 1'b0;
    n_tests++;
    if ({req_ready, mem_port} !== {1'b0, 2'b10, 14'd2, 4'b1111, 32'd0}) begin
      n_fail++; $display("FAIL b2b_load_access got %h want %h", {req_ready, mem_port}, {1'b0, 2'b10, 14'd2, 4'b1111, 32'd0});
    end
    step();
    step();
    n_tests++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL b2b_load_resp got %h want %h", {resp_valid, resp_rdata}, {1'b1, 32'hCAFEF00D});
    end
    step();
    n_tests++;
    if ({req_ready, resp_valid, mem_en} !== 3'b100) begin
      n_fail++; $display("FAIL b2b_final_idle got %b want 100", {req_ready, resp_valid, mem_en});
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'b0;
    req_wdata  = 32'b0;
    pl_en      = 1'b0;
    pl_addr    = '0;
    pl_dat     = 32'b0;
    #1;
    preload(14'd0,    32'h88442211);
    preload(14'd1,    32'hDDCCBBAA);
    preload(14'd2,    32'h44332211);
    preload(14'h3FFF, 32'h80000000);
    test_reset();
    test_byte_loads();
    test_split_load();
    test_split_store();
    test_wrap();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
